// File: rtl/phase_pkg.sv
// Shared phase encodings and default timing for the phase scheduler.
package phase_pkg;

  // Phase register encodings seen by the datapath.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    RUN   = 3'b010,
    HOLD  = 3'b011,
    ABORT = 3'b100,
    FLUSH = 3'b101
  } phase_t;

  localparam int DEF_CNT_W          = 16;
  localparam int DEF_LOAD_CYCLES    = 4;
  localparam int DEF_RUN_CYCLES     = 8;
  localparam int DEF_FLUSH_CYCLES   = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that saturates at zero; used as the per-phase dwell timer.
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             state_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge state_reset) begin
    if (!state_reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/phase_scheduler.sv
// Phase sequencer: IDLE->LOAD->RUN->HOLD with ABORT->FLUSH recovery, minimum
// dwell per phase, phase_done acknowledge and an acknowledge watchdog.
//
// Handshake: phase_done is a level acknowledge for the current LOAD/RUN phase.
// It may arrive in any cycle of the phase; it is remembered (done_seen) and the
// phase advances on the first edge where the dwell has expired and an
// acknowledge has been seen or is present.
module phase_scheduler
  import phase_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int LOAD_CYCLES    = DEF_LOAD_CYCLES,
  parameter int RUN_CYCLES     = DEF_RUN_CYCLES,
  parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             state_reset,
  input  logic             start,
  input  logic             abort,
  input  logic             clear,
  input  logic             phase_done,
  output logic [2:0]       state,
  output logic             phase_start,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] dwell_cnt
);

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  phase_t           state_q;
  phase_t           state_d;
  logic             phase_start_q;
  logic             timeout_q;
  logic             done_seen_q;
  logic [CNT_W-1:0] wd_q;
  logic             dwell_zero;
  logic             dwell_load;
  logic [CNT_W-1:0] dwell_value;
  logic             entering;
  logic             is_active;
  logic             ack;
  logic             wd_expire;
  logic             timeout_set;
  logic             timeout_clr;

  assign is_active = (state_q == LOAD) || (state_q == RUN);
  assign ack       = done_seen_q | phase_done;
  assign wd_expire = dwell_zero && !ack && (wd_q == WD_LAST);

  dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk         (clk),
    .state_reset (state_reset),
    .load        (dwell_load),
    .value       (dwell_value),
    .count       (dwell_cnt),
    .zero        (dwell_zero)
  );

  // Next phase with abort > watchdog > normal advance > hold, plus dwell load.
  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    timeout_clr = 1'b0;
    dwell_value = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          timeout_clr = 1'b1;
        end
      end
      LOAD, RUN: begin
        if (abort) begin
          state_d = ABORT;
        end else if (wd_expire) begin
          state_d     = ABORT;
          timeout_set = 1'b1;
        end else if (dwell_zero && ack) begin
          state_d = (state_q == LOAD) ? RUN : HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = ABORT;
        end else if (clear) begin
          state_d = IDLE;
        end
      end
      ABORT: state_d = FLUSH;
      FLUSH: begin
        if (dwell_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    entering   = (state_d != state_q);
    dwell_load = entering;
    case (state_d)
      LOAD:    dwell_value = LOAD_LAST;
      RUN:     dwell_value = RUN_LAST;
      FLUSH:   dwell_value = FLUSH_LAST;
      default: dwell_value = '0;
    endcase
  end

  // Phase register and the first-cycle pulse of every non-IDLE phase.
  always_ff @(posedge clk or negedge state_reset) begin
    if (!state_reset) begin
      state_q       <= IDLE;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_start_q <= entering && (state_d != IDLE);
    end
  end

  // Acknowledge memory and watchdog, both restarted on every phase entry.
  always_ff @(posedge clk or negedge state_reset) begin
    if (!state_reset) begin
      done_seen_q <= 1'b0;
      wd_q        <= '0;
    end else if (entering) begin
      done_seen_q <= 1'b0;
      wd_q        <= '0;
    end else if (is_active) begin
      if (phase_done) begin
        done_seen_q <= 1'b1;
      end
      if (dwell_zero && !ack) begin
        wd_q <= wd_q + CNT_W'(1);
      end
    end
  end

  // Sticky watchdog flag, cleared when a new run is accepted.
  always_ff @(posedge clk or negedge state_reset) begin
    if (!state_reset) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end else if (timeout_clr) begin
      timeout_q <= 1'b0;
    end
  end

  assign state       = state_q;
  assign phase_start = phase_start_q;
  assign busy        = (state_q != IDLE);
  assign timeout     = timeout_q;

endmodule
